ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 1600, clock-low inhibit time (100 us at 16 MHz).
REQ-002 The block SHALL have parameter RTS_CYCLES, default 32, time data is held low before the clock is released.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 32000, maximum gap between PS/2 clock falling edges (2 ms).
REQ-004 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  system clock, ck16 domain
- rst_n  in  1  async active-low reset
- send  in  1  request strobe; accepted only when busy=0
- data  in  8  byte to transmit, sampled with send
- clkps2_in  in  1  PS/2 clock line level (async)
- dataps2_in  in  1  PS/2 data line level (async)
- clkps2_oe  out  1  1 = pull PS/2 clock low, 0 = release
- dataps2_oe  out  1  1 = pull PS/2 data low, 0 = release
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- error  out  1  valid with done; 1 = no ACK or timeout

Function
REQ-006 clkps2_in and dataps2_in SHALL pass through 2-FF synchronizers; a PS/2 falling edge is synced clock 1 then 0 on consecutive clk cycles.
REQ-007 The FSM SHALL have states IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE.
REQ-008 In IDLE with send=1: latch data, compute parity = odd parity (~^data), clear bit counter, go to INHIBIT; busy=1 from the next cycle.
REQ-009 send while busy=1 SHALL be ignored with no effect on the transfer in progress.
REQ-010 INHIBIT: clkps2_oe=1, dataps2_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-011 RTS: clkps2_oe=1, dataps2_oe=1 (start bit) for RTS_CYCLES cycles; then clkps2_oe=0, go to SEND.
REQ-012 SEND: on PS/2 falling edges k=1..8, set dataps2_oe=~data[k-1] (LSB first).
REQ-013 SEND: edge 9 sets dataps2_oe=~parity; edge 10 sets dataps2_oe=0 (stop bit, line released) and enters WAIT_ACK.
REQ-014 WAIT_ACK: on the next falling edge, sample synced data; 0 = ACK, 1 = NACK (record error). Then go to WAIT_IDLE.
REQ-015 WAIT_IDLE: when synced clock and synced data are both 1, pulse done for one cycle with error valid, clear busy in the same cycle, and go to IDLE.
REQ-016 A timeout counter SHALL restart on entry to SEND and on every falling edge in SEND/WAIT_ACK/WAIT_IDLE.
REQ-017 On timeout expiry: release both lines, pulse done with error=1, go to IDLE.
REQ-018 Outside INHIBIT/RTS, clkps2_oe SHALL be 0; in IDLE, both oe outputs SHALL be 0.
REQ-019 error SHALL be 0 whenever done=0.
REQ-020 The next send SHALL be accepted on the cycle after done at the earliest.

Reset
REQ-021 rst_n=0 SHALL immediately (asynchronously) force state IDLE, clkps2_oe=0, dataps2_oe=0, busy=0, done=0, error=0, counters=0, and synchronizers=1.
REQ-022 Reset mid-transfer SHALL abandon the transfer with no done pulse; lines are released within the same cycle.

Verification
REQ-023 Send 0xED, device model clocks at 12.5 kHz and ACKs -> clkps2_oe low for 1600 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop bit released; done=1, error=0.
REQ-024 Send 0xF4 with ACK -> data bits 0,0,1,0,1,1,1,1; parity 0; done=1, error=0.
REQ-025 Device clocks but leaves data high at edge 11 -> done=1, error=1.
REQ-026 Device never clocks -> done=1, error=1 exactly TIMEOUT_CYCLES (±sync latency) after RTS ends; both oe=0.
REQ-027 Pulse send=1 with data=0x00 during the transfer of 0xED -> transmitted bits remain those of 0xED; only one done pulse.
REQ-028 rst_n low at edge 5 of a transfer -> both oe=0 and busy=0 immediately, no done; a send after rst_n high completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// one byte plus odd parity out on device-generated clocks and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1600,
    parameter int RTS_CYCLES     = 32,
    parameter int TIMEOUT_CYCLES = 32000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    input  logic       clkps2_in,
    input  logic       dataps2_in,
    output logic       clkps2_oe,
    output logic       dataps2_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic            clkps2_p0, clkps2_p1, clkps2_p2;
    logic            dataps2_p0, dataps2_p1;
    logic [PH_W-1:0] phase_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [3:0]      bit_cnt;
    logic [7:0]      data_lat;
    logic            parity_lat;
    logic            nack;

    logic ps2_fall;
    logic waiting;
    logic bus_idle;
    logic to_expired;
    logic timeout;
    logic accept;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Synchronizers: p1 is the synced level, p2 the previous synced clock level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkps2_p0  <= 1'b1;
            clkps2_p1  <= 1'b1;
            clkps2_p2  <= 1'b1;
            dataps2_p0 <= 1'b1;
            dataps2_p1 <= 1'b1;
        end else begin
            clkps2_p0  <= clkps2_in;
            clkps2_p1  <= clkps2_p0;
            clkps2_p2  <= clkps2_p1;
            dataps2_p0 <= dataps2_in;
            dataps2_p1 <= dataps2_p0;
        end
    end

    assign ps2_fall   = clkps2_p2 & ~clkps2_p1;
    assign waiting    = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_IDLE);
    assign bus_idle   = (state == WAIT_IDLE) && clkps2_p1 && dataps2_p1;
    assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout    = waiting && !ps2_fall && !bus_idle && to_expired;
    // The done cycle itself never accepts, so a new request lands the cycle after
    assign accept     = (state == IDLE) && send && !done;

    always_ff @(posedge clk) begin
        if (accept) begin
            data_lat   <= data;
            parity_lat <= odd_parity(data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (waiting) begin
            to_cnt <= ps2_fall ? '0 : to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clkps2_oe  <= 1'b0;
            dataps2_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            nack       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (timeout) begin
                clkps2_oe  <= 1'b0;
                dataps2_oe <= 1'b0;
                done       <= 1'b1;
                error      <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        clkps2_oe  <= 1'b0;
                        dataps2_oe <= 1'b0;
                        if (accept) begin
                            clkps2_oe <= 1'b1;
                            busy      <= 1'b1;
                            phase_cnt <= '0;
                            bit_cnt   <= '0;
                            nack      <= 1'b0;
                            state     <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (phase_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
                            phase_cnt  <= '0;
                            dataps2_oe <= 1'b1;
                            state      <= RTS;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        if (phase_cnt == PH_W'(RTS_CYCLES - 1)) begin
                            phase_cnt <= '0;
                            clkps2_oe <= 1'b0;
                            state     <= SEND;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    SEND: begin
                        // Edges 1..8 carry data LSB first, 9 parity, 10 releases for stop
                        if (ps2_fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'd8) begin
                                dataps2_oe <= ~data_lat[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                dataps2_oe <= ~parity_lat;
                            end else begin
                                dataps2_oe <= 1'b0;
                                state      <= WAIT_ACK;
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (ps2_fall) begin
                            nack  <= dataps2_p1;
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (bus_idle) begin
                            done  <= 1'b1;
                            error <= nack;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        clkps2_oe  <= 1'b0;
                        dataps2_oe <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device, expected
// results queued at send time and checked by a monitor on every done pulse.
module tb_ps2_host_tx;

    localparam int INH  = 1600;
    localparam int RTS  = 32;
    localparam int TO   = 4000;
    localparam int HALF = 40;

    typedef struct {
        logic       err;
        logic       chk;
        logic [9:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clkps2_in, dataps2_in;
    logic       clkps2_oe, dataps2_oe, busy, done, error;

    int         n_vec = 0;
    int         n_fail = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic [9:0] dev_frame;
    int         inh_run = 0, rts_run = 0, inh_last = 0, rts_last = 0;

    assign clkps2_in  = ~(clkps2_oe | dev_clk_low);
    assign dataps2_in = ~(dataps2_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send      (send),
        .data      (data),
        .clkps2_in (clkps2_in),
        .dataps2_in(dataps2_in),
        .clkps2_oe (clkps2_oe),
        .dataps2_oe(dataps2_oe),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            check("expectation_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done_error", error, e.err);
                check("done_clk_oe", clkps2_oe, 0);
                check("done_data_oe", dataps2_oe, 0);
                check("done_busy", busy, 0);
                if (e.chk) check("frame_bits", dev_frame, e.frame);
            end
        end else if (error) begin
            check("error_without_done", done, 1);
        end
        if (!rst_n) begin
            inh_run = 0;
            rts_run = 0;
        end else begin
            if (clkps2_oe && !dataps2_oe) inh_run++;
            else if (inh_run != 0) begin inh_last = inh_run; inh_run = 0; end
            if (clkps2_oe && dataps2_oe) rts_run++;
            else if (rts_run != 0) begin rts_last = rts_run; rts_run = 0; end
        end
    end

    task automatic do_send(input logic [7:0] d, input bit push, input exp_t e);
        check("idle_before_send", busy, 0);
        data = d;
        send = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        send = 1'b0;
        check("busy_after_send", busy, 1);
    endtask

    // Waits for the host to release the clock after RTS, then clocks 11 bits.
    task automatic device(input bit ack, input int abort_edge);
        int k;
        dev_frame = '0;
        k = 0;
        while (!clkps2_oe && k < 4000) begin @(negedge clk); k++; end
        while (clkps2_oe && k < 4000) begin @(negedge clk); k++; end
        check("rts_release_seen", k < 4000, 1);
        if (k >= 4000) return;
        check("start_bit_low", dataps2_in, 0);
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (e == abort_edge) begin
                repeat (10) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("reset_clk_oe", clkps2_oe, 0);
                check("reset_data_oe", dataps2_oe, 0);
                check("reset_busy", busy, 0);
                check("reset_done", done, 0);
                dev_clk_low = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (e <= 10) dev_frame[e-1] = dataps2_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin @(negedge clk); k++; end
        check("transfer_completes", busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int t0, dt, k;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", clkps2_oe, 0);
        check("rst_data_oe", dataps2_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xED with ACK
        do_send(8'hED, 1, '{1'b0, 1'b1, 10'h3ED});
        device(1, 0);
        wait_idle(300);
        check("inhibit_cycles", inh_last, INH);
        check("rts_cycles", rts_last, RTS);

        // 0xF4 with ACK, parity 0
        do_send(8'hF4, 1, '{1'b0, 1'b1, 10'h2F4});
        device(1, 0);
        wait_idle(300);

        // 0x55, device leaves data high at edge 11
        do_send(8'h55, 1, '{1'b1, 1'b1, 10'h355});
        device(0, 0);
        wait_idle(300);

        // Device never clocks
        do_send(8'hA5, 1, '{1'b1, 1'b0, 10'h000});
        k = 0;
        while (!clkps2_oe && k < 4000) begin @(negedge clk); k++; end
        while (clkps2_oe && k < 4000) begin @(negedge clk); k++; end
        t0 = cyc;
        k = 0;
        while (!done && k < TO + 200) begin @(negedge clk); k++; end
        dt = cyc - t0;
        n_vec++;
        if (!done || dt < TO - 3 || dt > TO + 3) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles (done=%0b), expected %0d +/-3", dt, done, TO);
        end
        wait_idle(50);

        // Stray send with 0x00 in the middle of 0xED
        do_send(8'hED, 1, '{1'b0, 1'b1, 10'h3ED});
        fork
            device(1, 0);
            begin
                repeat (INH + RTS + 300) @(negedge clk);
                check("busy_mid_transfer", busy, 1);
                data = 8'h00;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        wait_idle(300);
        repeat (50) @(negedge clk);
        check("single_done", exp_q.size(), 0);

        // Reset at edge 5, then a normal transfer
        do_send(8'h3C, 0, '{1'b0, 1'b0, 10'h000});
        device(1, 5);
        repeat (20) @(negedge clk);
        check("post_reset_busy", busy, 0);
        do_send(8'hF4, 1, '{1'b0, 1'b1, 10'h2F4});
        device(1, 0);
        wait_idle(300);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
